// File: rtl/s2mm_cmd_sink.sv
// rtl/s2mm_cmd_sink.sv - S2MM sink: command FIFO, beat-to-address binding, write port and per-command status
module s2mm_cmd_sink #(
  parameter int DATA_W    = 256,
  parameter int CMD_DEPTH = 4,
  parameter int ERRCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_axis_s2mm_cmd_tvalid,
  output logic                s_axis_s2mm_cmd_tready,
  input  logic [103:0]        s_axis_s2mm_cmd_tdata,
  input  logic                s_axis_s2mm_tvalid,
  output logic                s_axis_s2mm_tready,
  input  logic [DATA_W-1:0]   s_axis_s2mm_tdata,
  input  logic                s_axis_s2mm_tlast,
  output logic                m_axis_s2mm_sts_tvalid,
  input  logic                m_axis_s2mm_sts_tready,
  output logic [7:0]          m_axis_s2mm_sts_tdata,
  output logic                wr_en,
  output logic [63:0]         wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int AW        = $clog2(CMD_DEPTH);
  localparam int BEAT_B    = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DATA, S_DRAIN, S_STS} state_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] saddr;
    logic [22:0] btt;
  } cmd_t;

  state_t              state_q, state_d;
  cmd_t                fifo_mem [CMD_DEPTH];
  cmd_t                cmd_in, cmd_q;
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic                rdy_q;
  logic                fifo_empty, fifo_full;
  logic                cmd_push, cmd_pop;
  logic                data_rdy, beat_hs, sts_accept;
  logic [3:0]          tag_q;
  logic [63:0]         addr_q;
  logic [17:0]         beats_left_q, beats_calc;
  logic                slverr_q, decerr_q, interr_q, okay;
  logic                wr_en_q;
  logic [63:0]         wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic                unused_cmd_bits;

  assign cmd_in.tag   = s_axis_s2mm_cmd_tdata[99:96];
  assign cmd_in.saddr = s_axis_s2mm_cmd_tdata[95:32];
  assign cmd_in.btt   = s_axis_s2mm_cmd_tdata[22:0];
  assign unused_cmd_bits = ^{s_axis_s2mm_cmd_tdata[103:100], s_axis_s2mm_cmd_tdata[31:23]};

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign s_axis_s2mm_cmd_tready = rdy_q & ~fifo_full;
  assign cmd_push   = s_axis_s2mm_cmd_tvalid & s_axis_s2mm_cmd_tready;

  assign beats_calc = 18'(({1'b0, cmd_q.btt} + 24'd31) >> 5);
  assign okay       = ~(slverr_q | decerr_q | interr_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
      S_LOAD:  if (cmd_q.btt == '0 || cmd_q.saddr[4:0] != '0) state_d = S_STS;
               else state_d = S_DATA;
      S_DATA:  if (beat_hs) begin
                 if (s_axis_s2mm_tlast)        state_d = S_STS;
                 else if (beats_left_q == 18'd1) state_d = S_DRAIN;
               end
      S_DRAIN: if (data_rdy && s_axis_s2mm_tvalid && s_axis_s2mm_tlast) state_d = S_STS;
      S_STS:   if (m_axis_s2mm_sts_tready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_pop    = (state_q == S_IDLE) && !fifo_empty;
    data_rdy   = (state_q == S_DATA) || (state_q == S_DRAIN);
    beat_hs    = (state_q == S_DATA) && s_axis_s2mm_tvalid;
    sts_accept = (state_q == S_STS) && m_axis_s2mm_sts_tready;
  end

  always_ff @(posedge clk) begin
    if (cmd_push) fifo_mem[wr_ptr_q[AW-1:0]] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rdy_q        <= 1'b0;
      cmd_q        <= '0;
      tag_q        <= '0;
      addr_q       <= '0;
      beats_left_q <= '0;
      slverr_q     <= 1'b0;
      decerr_q     <= 1'b0;
      interr_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      rdy_q   <= 1'b1;
      wr_en_q <= beat_hs;
      if (cmd_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (cmd_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        cmd_q    <= fifo_mem[rd_ptr_q[AW-1:0]];
      end
      if (state_q == S_LOAD) begin
        tag_q        <= cmd_q.tag;
        addr_q       <= cmd_q.saddr;
        beats_left_q <= beats_calc;
        interr_q     <= (cmd_q.btt == '0);
        decerr_q     <= (cmd_q.saddr[4:0] != '0);
        slverr_q     <= 1'b0;
      end
      if (beat_hs) begin
        wr_addr_q    <= addr_q;
        wr_data_q    <= s_axis_s2mm_tdata;
        addr_q       <= addr_q + 64'(BEAT_B);
        beats_left_q <= beats_left_q - 1'b1;
        // Early tlast and missing tlast are both a length mismatch.
        if (s_axis_s2mm_tlast != (beats_left_q == 18'd1)) slverr_q <= 1'b1;
      end
      if (sts_accept && !okay && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign s_axis_s2mm_tready     = data_rdy;
  assign m_axis_s2mm_sts_tvalid = (state_q == S_STS);
  assign m_axis_s2mm_sts_tdata  = (state_q == S_STS) ? {okay, slverr_q, decerr_q, interr_q, tag_q} : 8'h00;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != S_IDLE) | ~fifo_empty;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_s2mm_cmd_sink.sv
// tb/tb_s2mm_cmd_sink.sv - directed self-checking bench for s2mm_cmd_sink
module tb_s2mm_cmd_sink;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_tvalid, cmd_tready;
  logic [103:0] cmd_tdata;
  logic         s_tvalid, s_tready, s_tlast;
  logic [255:0] s_tdata;
  logic         sts_tvalid, sts_tready;
  logic [7:0]   sts_tdata;
  logic         wr_en;
  logic [63:0]  wr_addr;
  logic [255:0] wr_data;
  logic         busy;
  logic [15:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  int nacc  = 0;
  int beat_no = 0;
  logic [63:0]  wa [$];
  logic [255:0] wd [$];
  logic [7:0]   sq [$];

  always #5 clk = ~clk;

  s2mm_cmd_sink #(.DATA_W(256), .CMD_DEPTH(4), .ERRCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_s2mm_cmd_tvalid(cmd_tvalid), .s_axis_s2mm_cmd_tready(cmd_tready),
    .s_axis_s2mm_cmd_tdata(cmd_tdata),
    .s_axis_s2mm_tvalid(s_tvalid), .s_axis_s2mm_tready(s_tready),
    .s_axis_s2mm_tdata(s_tdata), .s_axis_s2mm_tlast(s_tlast),
    .m_axis_s2mm_sts_tvalid(sts_tvalid), .m_axis_s2mm_sts_tready(sts_tready),
    .m_axis_s2mm_sts_tdata(sts_tdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err_cnt(err_cnt)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
      end
      if (sts_tvalid && sts_tready) sq.push_back(sts_tdata);
      if (s_tvalid && s_tready) nacc++;
    end
  end

  function automatic logic [103:0] mk_cmd(input logic [22:0] btt, input logic [63:0] saddr,
                                          input logic [3:0] tag);
    logic [103:0] c;
    c = '0;
    c[22:0]  = btt;
    c[23]    = 1'b1;
    c[30]    = 1'b1;
    c[95:32] = saddr;
    c[99:96] = tag;
    return c;
  endfunction

  function automatic logic [255:0] pat(input int k);
    return {32'hC0DE0000 + 32'(k), 192'h0, 32'hD0000000 + 32'(k)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input string tag, input logic [103:0] c);
    int n;
    logic hs;
    cmd_tdata  = c;
    cmd_tvalid = 1'b1;
    n = 0;
    do begin
      hs = cmd_tready;
      tick();
      n++;
    end while (!hs && n < 200);
    cmd_tvalid = 1'b0;
    check(tag, hs, 1'b1);
  endtask

  task automatic send_beats(input string tag, input int n, input int last_idx, output int first_w);
    int w;
    logic hs;
    first_w = 0;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = pat(beat_no);
      s_tlast  = (i == last_idx);
      w = 0;
      do begin
        hs = s_tready;
        tick();
        w++;
      end while (!hs && w < 200);
      if (i == 0) first_w = w;
      beat_no++;
      if (!hs) check(tag, hs, 1'b1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_sts(input string tag, input int target);
    int n;
    n = 0;
    while (sq.size() < target && n < 200) begin
      tick();
      n++;
    end
    check(tag, sq.size() >= target, 1'b1);
  endtask

  initial begin
    int w;
    int n0;
    rst_n      = 1'b0;
    cmd_tvalid = 1'b0;
    cmd_tdata  = '0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    s_tlast    = 1'b0;
    sts_tready = 1'b1;
    tick(); tick();

    check("rst_cmd_tready", cmd_tready, 1'b0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_sts_tvalid", sts_tvalid, 1'b0);
    check("rst_sts_tdata", sts_tdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_tready", cmd_tready, 1'b1);

    // T1 clean 2-beat transfer
    send_cmd("t1_cmd", mk_cmd(23'd64, 64'h0A00_0000, 4'd3));
    send_beats("t1_beats", 2, 1, w);
    check("t1_latency", w, 3);
    wait_sts("t1_sts_wait", 1);
    check("t1_sts", sq[0], 8'h83);
    check("t1_nwr", wa.size(), 2);
    check("t1_addr0", wa[0], 64'h0A00_0000);
    check("t1_addr1", wa[1], 64'h0A00_0020);
    check("t1_data1", wd[1], pat(1));
    check("t1_err_cnt", err_cnt, 16'd0);
    check("t1_busy", busy, 1'b0);

    // T2 early tlast on an oversized BTT
    send_cmd("t2_cmd", mk_cmd(23'd1200, 64'h1000, 4'd0));
    send_beats("t2_beats", 8, 7, w);
    wait_sts("t2_sts_wait", 2);
    check("t2_sts", sq[1], 8'h40);
    check("t2_nwr", wa.size(), 10);
    check("t2_addr_last", wa[9], 64'h10E0);
    check("t2_err_cnt", err_cnt, 16'd1);

    // T3 missing tlast: extra beats drained
    n0 = nacc;
    send_cmd("t3_cmd", mk_cmd(23'd64, 64'h2000, 4'd0));
    send_beats("t3_beats", 4, 3, w);
    wait_sts("t3_sts_wait", 3);
    check("t3_sts", sq[2], 8'h40);
    check("t3_nwr", wa.size(), 12);
    check("t3_addr1", wa[11], 64'h2020);
    check("t3_data1", wd[11], pat(11));
    check("t3_nacc", nacc - n0, 4);
    check("t3_err_cnt", err_cnt, 16'd2);

    // T4 zero BTT and misaligned SADDR consume no data
    n0 = nacc;
    s_tvalid = 1'b1;
    s_tdata  = pat(999);
    send_cmd("t4a_cmd", mk_cmd(23'd0, 64'h0, 4'd5));
    wait_sts("t4a_sts_wait", 4);
    check("t4a_sts", sq[3], 8'h15);
    send_cmd("t4b_cmd", mk_cmd(23'd64, 64'h10, 4'd1));
    wait_sts("t4b_sts_wait", 5);
    check("t4b_sts", sq[4], 8'h21);
    s_tvalid = 1'b0;
    check("t4_nacc", nacc - n0, 0);
    check("t4_nwr", wa.size(), 12);
    check("t4_err_cnt", err_cnt, 16'd4);

    // T5 FIFO fills while a transfer is parked in DATA
    send_cmd("t5_c0", mk_cmd(23'd64, 64'h5000, 4'd6));
    tick(); tick();
    check("t5_in_data", s_tready, 1'b1);
    send_cmd("t5_c1", mk_cmd(23'd0, 64'h0, 4'd7));
    send_cmd("t5_c2", mk_cmd(23'd0, 64'h0, 4'd8));
    send_cmd("t5_c3", mk_cmd(23'd0, 64'h0, 4'd9));
    send_cmd("t5_c4", mk_cmd(23'd0, 64'h0, 4'd10));
    check("t5_full", cmd_tready, 1'b0);
    cmd_tdata  = mk_cmd(23'd0, 64'h0, 4'd11);
    cmd_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t5_still_full", cmd_tready, 1'b0);
    check("t5_busy", busy, 1'b1);
    send_beats("t5_beats", 2, 1, w);
    send_cmd("t5_c5", mk_cmd(23'd0, 64'h0, 4'd11));
    wait_sts("t5_sts_wait", 11);
    check("t5_sts0", sq[5], 8'h86);
    check("t5_sts1", sq[6], 8'h17);
    check("t5_sts2", sq[7], 8'h18);
    check("t5_sts3", sq[8], 8'h19);
    check("t5_sts4", sq[9], 8'h1A);
    check("t5_sts5", sq[10], 8'h1B);
    check("t5_addr1", wa[13], 64'h5020);
    check("t5_err_cnt", err_cnt, 16'd9);

    // T6a status backpressure
    sts_tready = 1'b0;
    send_cmd("t6a_cmd", mk_cmd(23'd32, 64'h3000, 4'd2));
    send_beats("t6a_beats", 1, 0, w);
    n0 = 0;
    while (!sts_tvalid && n0 < 50) begin
      tick();
      n0++;
    end
    for (int i = 0; i < 10; i++) begin
      check("t6a_hold_valid", sts_tvalid, 1'b1);
      check("t6a_hold_data", sts_tdata, 8'h82);
      check("t6a_hold_tready", s_tready, 1'b0);
      tick();
    end
    sts_tready = 1'b1;
    wait_sts("t6a_sts_wait", 12);
    check("t6a_sts", sq[11], 8'h82);
    check("t6a_addr", wa[14], 64'h3000);
    check("t6a_err_cnt", err_cnt, 16'd9);

    // T6b reset in the middle of a transfer with a queued command
    send_cmd("t6b_cmd", mk_cmd(23'd128, 64'h4000, 4'd4));
    send_beats("t6b_beats", 1, -1, w);
    send_cmd("t6b_cmd2", mk_cmd(23'd0, 64'h0, 4'd9));
    check("t6b_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("t6b_rst_wr_en", wr_en, 1'b0);
    check("t6b_rst_wr_addr", wr_addr, 64'h0);
    check("t6b_rst_wr_data", wr_data, 256'h0);
    check("t6b_rst_busy", busy, 1'b0);
    check("t6b_rst_s_tready", s_tready, 1'b0);
    check("t6b_rst_cmd_tready", cmd_tready, 1'b0);
    check("t6b_rst_sts_tvalid", sts_tvalid, 1'b0);
    check("t6b_rst_err_cnt", err_cnt, 16'd0);
    rst_n = 1'b1;
    tick();
    check("t6b_cmd_tready", cmd_tready, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    check("t6b_no_sts", sq.size(), 12);
    check("t6b_idle", busy, 1'b0);
    check("t6b_nwr", wa.size(), 16);
    check("t6b_addr", wa[15], 64'h4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
